// File: rtl/lock_key_ctrl.sv
// Serial key loader for the locked c432 core: shifts in KEY_W bits plus even parity,
// commits good keys atomically, scrambles on zeroize and locks out after MAX_FAIL bad loads.
module lock_key_ctrl #(
  parameter int              KEY_W        = 10,
  parameter logic [KEY_W-1:0] SCRAMBLE_KEY = 10'h2A5,
  parameter int              TIMEOUT      = 64,
  parameter int              MAX_FAIL     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             zeroize,
  output logic [KEY_W-1:0] key_out,
  output logic             key_active,
  output logic             load_err,
  output logic             locked_out,
  output logic [2:0]       fail_cnt
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, LOCKOUT} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               active_q, active_d;
  logic               err_q, err_d;
  logic               lock_q, lock_d;
  logic [2:0]         fail_q, fail_d;

  logic               accept;
  logic [TMR_W-1:0]   timer_inc;
  logic               parity_ok;
  logic [3:0]         fail_inc;

  assign accept    = (state_q == LOAD) && key_valid;
  assign timer_inc = timer_q + 1'b1;
  assign parity_ok = ~((^shadow_q) ^ par_q);
  assign fail_inc  = {1'b0, fail_q} + 4'd1;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    key_d     = key_q;
    active_d  = active_q;
    err_d     = err_q;
    lock_d    = lock_q;
    fail_d    = fail_q;

    if (state_q == LOCKOUT) begin
      key_d    = SCRAMBLE_KEY;
      active_d = 1'b0;
      lock_d   = 1'b1;
    end else if (zeroize) begin
      // Zeroize beats any load or commit; error history is kept.
      state_d   = IDLE;
      key_d     = SCRAMBLE_KEY;
      active_d  = 1'b0;
      shadow_d  = '0;
      par_d     = 1'b0;
      bit_cnt_d = '0;
      timer_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
            timer_d   = '0;
            err_d     = 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            timer_d = '0;
            if (bit_cnt_q == CNT_W'(KEY_W)) begin
              par_d   = key_bit;
              state_d = CHECK;
            end else begin
              shadow_d  = {shadow_q[KEY_W-2:0], key_bit};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (timer_inc == TMR_W'(TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        CHECK: begin
          state_d = IDLE;
          if (parity_ok) begin
            key_d    = shadow_q;
            active_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            fail_d = (fail_q == 3'd7) ? 3'd7 : fail_inc[2:0];
            if (fail_inc == 4'(MAX_FAIL)) begin
              state_d  = LOCKOUT;
              key_d    = SCRAMBLE_KEY;
              active_d = 1'b0;
              lock_d   = 1'b1;
            end
          end
        end
        default: state_d = LOCKOUT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      key_q     <= SCRAMBLE_KEY;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
      fail_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      key_q     <= key_d;
      active_q  <= active_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
      fail_q    <= fail_d;
    end
  end

  assign key_ready  = (state_q == LOAD);
  assign key_out    = key_q;
  assign key_active = active_q;
  assign load_err   = err_q;
  assign locked_out = lock_q;
  assign fail_cnt   = fail_q;

endmodule
